// File: rtl/cr_tlvp_ob_arb_if.sv
// Bundle of the requester-side beat streams and the single sink-side output stream
// of the frame-atomic TLV arbiter.
interface cr_tlvp_ob_arb_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 64
) ();
  localparam int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_empty;
  logic [N_REQ-1:0]        req_eot;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_rd;
  logic                    ob_rd;
  logic                    ob_empty;
  logic [DATA_W-1:0]       ob_data;
  logic                    ob_eot;
  logic [SRC_W-1:0]        ob_src;
  logic                    arb_error;

  // Arbiter side
  modport slave (
    input  req_empty, req_eot, req_data, ob_rd,
    output req_rd, ob_empty, ob_data, ob_eot, ob_src, arb_error
  );

  // Sources and sink side
  modport master (
    output req_empty, req_eot, req_data, ob_rd,
    input  req_rd, ob_empty, ob_data, ob_eot, ob_src, arb_error
  );
endinterface

// File: rtl/cr_tlvp_ob_arb.sv
// Frame-atomic round-robin arbiter: merges N_REQ FIFO-style TLV beat streams onto one
// registered FIFO-style output; a grant is held from first beat to the eot beat.
module cr_tlvp_ob_arb #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BEATS = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cr_tlvp_ob_arb_if.slave        bus
);
  localparam int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   grant_q, grant_d;
  logic [SRC_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               ob_empty_q, ob_empty_d;
  logic [DATA_W-1:0]  ob_data_q, ob_data_d;
  logic               ob_eot_q, ob_eot_d;
  logic [SRC_W-1:0]   ob_src_q, ob_src_d;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   req_rd_c;
  logic               head_empty;
  logic               head_eot;
  logic [DATA_W-1:0]  head_data;
  logic               pick_vld;
  logic [SRC_W-1:0]   pick;
  logic               pop;
  int unsigned        idx;

  // Head beat of the granted requester
  always_comb begin
    head_empty = 1'b1;
    head_eot   = 1'b0;
    head_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q == SRC_W'(i)) begin
        head_empty = bus.req_empty[i];
        head_eot   = bus.req_eot[i];
        head_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin pick: first non-empty requester after the last granted one
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_grant_q) + k) % N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!pick_vld && (i == idx) && !bus.req_empty[i]) begin
          pick_vld = 1'b1;
          pick     = SRC_W'(i);
        end
      end
    end
  end

  // Next-state and pop strobe
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    ob_empty_d   = ob_empty_q;
    ob_data_d    = ob_data_q;
    ob_eot_d     = ob_eot_q;
    ob_src_d     = ob_src_q;
    err_d        = err_q | (bus.ob_rd & ob_empty_q);
    req_rd_c     = '0;
    pop          = 1'b0;

    if (bus.ob_rd) begin
      ob_empty_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
        pop = !head_empty && (ob_empty_q || bus.ob_rd);
        if (pop) begin
          req_rd_c[grant_q] = 1'b1;
          ob_data_d  = head_data;
          ob_eot_d   = head_eot;
          ob_src_d   = grant_q;
          ob_empty_d = 1'b0;
          if (head_eot) begin
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            state_d      = IDLE;
          end else if (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) begin
            // Oversize frame: flag it, keep the grant, hold the count
            err_d = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_W'(N_REQ - 1);
      beat_cnt_q   <= '0;
      ob_empty_q   <= 1'b1;
      ob_data_q    <= '0;
      ob_eot_q     <= 1'b0;
      ob_src_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      ob_empty_q   <= ob_empty_d;
      ob_data_q    <= ob_data_d;
      ob_eot_q     <= ob_eot_d;
      ob_src_q     <= ob_src_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_rd    = req_rd_c;
  assign bus.ob_empty  = ob_empty_q;
  assign bus.ob_data   = ob_data_q;
  assign bus.ob_eot    = ob_eot_q;
  assign bus.ob_src    = ob_src_q;
  assign bus.arb_error = err_q;
endmodule

// File: tb/tb_cr_tlvp_ob_arb.sv
// Bench for cr_tlvp_ob_arb: queue-based sources and sink, a transaction-level model of
// frame-atomic round-robin merging, and directed scenarios with literal expectations.
module tb_cr_tlvp_ob_arb;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cr_tlvp_ob_arb_if #(.N_REQ(N), .DATA_W(DW)) bus ();
  cr_tlvp_ob_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Source queues and sink controls
  logic [DW-1:0] q_data [N][$];
  bit            q_eot  [N][$];
  bit            sink_ready;
  bit            force_rd;
  int            seq;

  // Model state
  bit            m_ob_valid;
  logic [DW-1:0] m_ob_data;
  bit            m_ob_eot;
  int            m_ob_src;
  bit            m_err;
  bit            m_in_frame;
  int            m_cur;
  int            m_last;
  int            m_beats;

  // Logs for literal checks
  int            sink_src [$];
  logic [DW-1:0] sink_data [$];
  int            pop_cyc [$];
  int            pop_cnt;
  int            pops_at_err;
  bit            err_seen;
  int            cyc;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_empty[i] = (q_data[i].size() == 0);
      bus.req_eot[i]   = (q_data[i].size() != 0) ? q_eot[i][0] : 1'b0;
      bus.req_data[i*DW +: DW] = (q_data[i].size() != 0) ? q_data[i][0] : '0;
    end
    bus.ob_rd = force_rd || (sink_ready && !bus.ob_empty);
  endtask

  task automatic add_frame(input int s, input int n, input bit last_eot);
    for (int b = 0; b < n; b++) begin
      q_data[s].push_back(DW'((s << 12) | seq));
      q_eot[s].push_back(last_eot && (b == n - 1));
      seq++;
    end
    drive();
  endtask

  task automatic model_reset();
    m_ob_valid = 0; m_ob_data = '0; m_ob_eot = 0; m_ob_src = 0;
    m_err = 0; m_in_frame = 0; m_cur = 0; m_last = N - 1; m_beats = 0;
    for (int i = 0; i < N; i++) begin
      q_data[i].delete();
      q_eot[i].delete();
    end
  endtask

  task automatic clear_logs();
    sink_src.delete(); sink_data.delete(); pop_cyc.delete();
    pop_cnt = 0; seq = 0; err_seen = 0; pops_at_err = -1;
  endtask

  // One clock: compare DUT against the model mid-cycle, advance the model, apply pops
  task automatic tick();
    logic [N-1:0] exp_rd;
    int pop_src;
    bit found;
    int k_idx;
    @(negedge clk);
    cyc++;
    exp_rd  = '0;
    pop_src = -1;
    if (rst_n) begin
      if (m_in_frame && q_data[m_cur].size() > 0 && (!m_ob_valid || bus.ob_rd)) begin
        exp_rd[m_cur] = 1'b1;
        pop_src = m_cur;
      end
      chk("ob_empty", 64'(bus.ob_empty), 64'(!m_ob_valid));
      if (m_ob_valid) begin
        chk("ob_data", 64'(bus.ob_data), 64'(m_ob_data));
        chk("ob_eot",  64'(bus.ob_eot),  64'(m_ob_eot));
        chk("ob_src",  64'(bus.ob_src),  64'(m_ob_src));
      end
      chk("arb_error", 64'(bus.arb_error), 64'(m_err));
      chk("req_rd", 64'(bus.req_rd), 64'(exp_rd));
      if (bus.arb_error === 1'b1 && !err_seen) begin
        err_seen = 1;
        pops_at_err = pop_cnt;
      end
      if (bus.ob_rd && !m_ob_valid) m_err = 1;
      if (bus.ob_rd && m_ob_valid) begin
        sink_src.push_back(m_ob_src);
        sink_data.push_back(m_ob_data);
      end
      if (pop_src >= 0) begin
        m_ob_valid = 1;
        m_ob_data  = q_data[pop_src][0];
        m_ob_eot   = q_eot[pop_src][0];
        m_ob_src   = pop_src;
        pop_cnt++;
        pop_cyc.push_back(cyc);
        if (m_ob_eot) begin
          m_in_frame = 0; m_last = pop_src; m_beats = 0;
        end else if (m_beats == MB - 1) begin
          m_err = 1;
        end else begin
          m_beats++;
        end
      end else if (bus.ob_rd) begin
        m_ob_valid = 0;
      end
      if (!m_in_frame && pop_src < 0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          k_idx = (m_last + k) % N;
          if (!found && q_data[k_idx].size() > 0) begin
            found = 1; m_in_frame = 1; m_cur = k_idx;
          end
        end
      end
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    if (pop_src >= 0) begin
      void'(q_data[pop_src].pop_front());
      void'(q_eot[pop_src].pop_front());
    end
    drive();
  endtask

  task automatic drain(input int limit);
    int n;
    bit busy;
    n = 0;
    busy = 1;
    while (busy && n < limit) begin
      tick();
      n++;
      busy = m_ob_valid || m_in_frame;
      for (int i = 0; i < N; i++) if (q_data[i].size() != 0) busy = 1;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", limit);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive();
    tick();
    rst_n = 1'b1;
    drive();
  endtask

  int exp2 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int exp3 [5] = '{1, 1, 1, 2, 2};
  int exp6 [4] = '{0, 0, 2, 2};
  logic [DW-1:0] exp4 [4] = '{16'h3000, 16'h3001, 16'h3002, 16'h3003};
  int add_cyc;

  initial begin
    cyc = 0; sink_ready = 1; force_rd = 0; rst_n = 1'b0;
    bus.ob_rd = 1'b0;
    model_reset();
    clear_logs();
    drive();
    tick();
    do_reset();
    chk("rst_ob_empty", 64'(bus.ob_empty), 64'd1);
    chk("rst_ob_data",  64'(bus.ob_data), 64'd0);
    chk("rst_ob_eot",   64'(bus.ob_eot), 64'd0);
    chk("rst_ob_src",   64'(bus.ob_src), 64'd0);
    chk("rst_err",      64'(bus.arb_error), 64'd0);
    chk("rst_req_rd",   64'(bus.req_rd), 64'd0);

    // 1: single 3-beat frame from req0, sink always ready
    clear_logs();
    add_cyc = cyc;
    add_frame(0, 3, 1);
    drain(50);
    chk("t1_pops", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      chk("t1_first_pop", 64'(pop_cyc[0] - add_cyc), 64'd2);
      chk("t1_contig", 64'(pop_cyc[2] - pop_cyc[0]), 64'd2);
    end
    chk("t1_delivered", 64'(sink_src.size()), 64'd3);

    // 2: all four requesters with 2-beat frames after reset
    do_reset();
    clear_logs();
    for (int s = 0; s < N; s++) add_frame(s, 2, 1);
    drain(100);
    chk("t2_count", 64'(sink_src.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < sink_src.size()) chk("t2_order", 64'(sink_src[i]), 64'(exp2[i]));

    // 3: req1 runs dry mid-frame while req2 waits
    clear_logs();
    add_frame(1, 1, 0);
    add_frame(2, 2, 1);
    repeat (3) tick();
    repeat (5) tick();
    add_frame(1, 2, 1);
    drain(100);
    chk("t3_count", 64'(sink_src.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < sink_src.size()) chk("t3_order", 64'(sink_src[i]), 64'(exp3[i]));
    chk("t3_err", 64'(bus.arb_error), 64'd0);

    // 4: sink stalls for 4 cycles mid-frame
    clear_logs();
    add_frame(3, 4, 1);
    repeat (3) tick();
    sink_ready = 0;
    drive();
    repeat (4) tick();
    sink_ready = 1;
    drive();
    drain(100);
    chk("t4_count", 64'(sink_data.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < sink_data.size()) chk("t4_data", 64'(sink_data[i]), 64'(exp4[i]));

    // 5: oversize 6-beat frame with MAX_BEATS=4
    clear_logs();
    add_frame(0, 6, 1);
    drain(100);
    chk("t5_err_at_pop", 64'(pops_at_err), 64'd4);
    chk("t5_delivered", 64'(sink_data.size()), 64'd6);
    chk("t5_err_sticky", 64'(bus.arb_error), 64'd1);

    // 6: read of an empty output, then reset mid-frame
    do_reset();
    clear_logs();
    chk("t6_err_clear", 64'(bus.arb_error), 64'd0);
    force_rd = 1;
    drive();
    tick();
    force_rd = 0;
    drive();
    chk("t6_err_set", 64'(bus.arb_error), 64'd1);
    add_frame(0, 1, 1);
    drain(50);
    add_frame(1, 4, 1);
    repeat (3) tick();
    do_reset();
    chk("t6_rst_empty", 64'(bus.ob_empty), 64'd1);
    chk("t6_rst_err", 64'(bus.arb_error), 64'd0);
    clear_logs();
    add_frame(2, 2, 1);
    add_frame(0, 2, 1);
    drain(100);
    chk("t6_count", 64'(sink_src.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < sink_src.size()) chk("t6_order", 64'(sink_src[i]), 64'(exp6[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
